spm_mem_pipe: RTL and testbench
===============================

SPM_MEM_PIPE -- requirements
Module: spm_mem_pipe

Interface
- REQ-001 SHALL have parameter AddrWidth, default 18: byte address width of the tile memory space.
- REQ-002 SHALL have parameter DataWidth, default 64: word width; strobe width is DataWidth/8.
- REQ-003 SHALL have parameter SramAddrWidth, default 10: word index width towards one SRAM bank.
- REQ-004 SHALL have parameter RspFifoDepth, default 2, legal range 1..8: maximum number of outstanding reads.
- REQ-005 SHALL have one clock; reset is synchronous and active-high.
- REQ-006 clk_i  in  1  clock; all flops on its rising edge.
- REQ-007 rst_i  in  1  synchronous, active-high reset.
- REQ-008 req_valid_i  in  1  upstream request valid.
- REQ-009 req_ready_o  out  1  request accepted when valid&&ready.
- REQ-010 req_we_i  in  1  1 = write, 0 = read.
- REQ-011 req_addr_i  in  AddrWidth  byte address.
- REQ-012 req_wdata_i  in  DataWidth  write data.
- REQ-013 req_strb_i  in  DataWidth/8  byte enables.
- REQ-014 rsp_valid_o  out  1  read data valid.
- REQ-015 rsp_ready_i  in  1  response consumed when valid&&ready.
- REQ-016 rsp_rdata_o  out  DataWidth  read data.
- REQ-017 sram_req_o / sram_we_o  out  1 each  SRAM access strobe / write enable.
- REQ-018 sram_addr_o  out  SramAddrWidth  word address = req_addr_i[log2(DataWidth/8) +: SramAddrWidth].
- REQ-019 sram_wdata_o / sram_be_o  out  DataWidth / DataWidth/8  write data / byte enables.
- REQ-020 sram_rdata_i  in  DataWidth  SRAM read data, valid exactly one cycle after sram_req_o&&!sram_we_o.
- REQ-021 rd_cnt_o, wr_cnt_o, stall_cnt_o  out  32 each  performance counters (see Configuration).

Function
- REQ-022 SHALL hold one request-stage register; req_ready_o = !stage_valid || stage_issue, with no combinational path from req_valid_i.
- REQ-023 stage_issue SHALL be stage_valid && (stage_we || credits > 0); sram_req_o = stage_issue; other sram_* outputs come from the stage register.
- REQ-024 credits SHALL be a counter initialised to RspFifoDepth, decremented on each read issue, incremented on each response pop; a simultaneous issue and pop leaves it unchanged; it never exceeds RspFifoDepth or goes below 0.
- REQ-025 Writes SHALL consume no credit and produce no response; at credits == 0 a stalled read blocks all younger requests (in-order).
- REQ-026 A rd_pending flop SHALL capture each read issue; when set, sram_rdata_i SHALL be pushed into the response FIFO (depth RspFifoDepth); overflow is impossible by construction.
- REQ-027 Read latency: accept at edge N -> sram_req_o high in cycle N+1 -> FIFO push at edge N+2 -> rsp_valid_o high from cycle N+2 after that edge (3 cycles accept-to-valid), with rsp_ready_i tied high and no stall.
- REQ-028 Sustained throughput SHALL be 1 request/cycle while credits allow; responses SHALL be returned in issue order; rsp_rdata_o SHALL stay stable while rsp_valid_o && !rsp_ready_i.

Reset
- REQ-029 While rst_i is high: stage_valid=0, rd_pending=0, FIFO empty, credits=RspFifoDepth, counters=0; hence req_ready_o=1, rsp_valid_o=0, sram_req_o=0.
- REQ-030 Reset asserted mid-operation SHALL drop staged and in-flight requests; sram_rdata_i returned the cycle after reset SHALL be discarded.

Configuration
- REQ-031 Macro SPM_MEM_PIPE_PERF_EN defined: rd_cnt_o / wr_cnt_o count issued reads / writes, stall_cnt_o counts cycles with req_valid_i && !req_ready_o; all three saturate at 2^32-1.
- REQ-032 Macro SPM_MEM_PIPE_PERF_EN undefined: no counter flops are instantiated; rd_cnt_o, wr_cnt_o, stall_cnt_o are tied to 0.

Verification
- REQ-033 Write addr 0x40, wdata 0xDEAD_BEEF, strb 0xFF, then read addr 0x40 -> sram_addr_o = 0x8 for both; rsp_rdata_o = 0xDEAD_BEEF, rsp_valid_o 3 cycles after read acceptance.
- REQ-034 RspFifoDepth=2, rsp_ready_i=0, issue 3 reads -> 2 issued to SRAM, 3rd held, req_ready_o=0; raise rsp_ready_i for 1 cycle -> 3rd read issues the next cycle.
- REQ-035 Credits=0 with a read stalled, then a write queued behind it -> write not issued until the read issues (in-order check).
- REQ-036 Back-to-back reads to addresses 0x0, 0x8, 0x10 with rsp_ready_i=1 -> 1 access/cycle and responses in order.
- REQ-037 Assert rst_i one cycle after a read issues -> no rsp_valid_o ever for that read; credits back at RspFifoDepth.
- REQ-038 With PERF_EN: 5 reads, 2 writes, 4 stall cycles -> counters read 5/2/4; without PERF_EN -> all counters read 0.

Source files
------------

// File: rtl/spm_mem_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spm_mem_pipe_if                                               |
// | Purpose  : Bundles the request, response and SRAM-side signals of        |
// |            spm_mem_pipe into one interface.                              |
// | Modports : slave  - the pipeline (takes requests, drives SRAM, returns   |
// |                     read data)                                           |
// |            master - the environment (upstream requester + SRAM bank)     |
// | Ports    : req_*  request channel (valid/ready, we, addr, wdata, strb)   |
// |            rsp_*  read response channel (valid/ready, rdata)             |
// |            sram_* single-bank SRAM access port                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface spm_mem_pipe_if #(
   parameter int AddrWidth     = 18,
   parameter int DataWidth     = 64,
   parameter int SramAddrWidth = 10
);
   logic                     req_valid_i;
   logic                     req_ready_o;
   logic                     req_we_i;
   logic [AddrWidth-1:0]     req_addr_i;
   logic [DataWidth-1:0]     req_wdata_i;
   logic [DataWidth/8-1:0]   req_strb_i;
   logic                     rsp_valid_o;
   logic                     rsp_ready_i;
   logic [DataWidth-1:0]     rsp_rdata_o;
   logic                     sram_req_o;
   logic                     sram_we_o;
   logic [SramAddrWidth-1:0] sram_addr_o;
   logic [DataWidth-1:0]     sram_wdata_o;
   logic [DataWidth/8-1:0]   sram_be_o;
   logic [DataWidth-1:0]     sram_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_strb_i,
      input  rsp_ready_i, sram_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o,
      output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_strb_i,
      output rsp_ready_i, sram_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o,
      input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
   );
endinterface
`default_nettype wire

// File: rtl/spm_mem_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spm_mem_pipe                                                  |
// | Purpose  : Scratchpad memory access pipeline. One request-stage register |
// |            feeds a single SRAM bank; reads are credit-limited so that    |
// |            every issued read has a guaranteed slot in the in-order       |
// |            response FIFO.                                                |
// | Ports    : clk_i  clock, rising edge                                     |
// |            rst_i  synchronous active-high reset                          |
// |            bus    spm_mem_pipe_if.slave (request, response, SRAM port)   |
// |            rd_cnt_o / wr_cnt_o / stall_cnt_o  32-bit perf counters       |
// | Config   : SPM_MEM_PIPE_PERF_EN - when defined, the three counters are   |
// |            live saturating counters; otherwise they are tied to zero.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spm_mem_pipe #(
   parameter int AddrWidth     = 18,
   parameter int DataWidth     = 64,
   parameter int SramAddrWidth = 10,
   parameter int RspFifoDepth  = 2
) (
   input  wire logic        clk_i,
   input  wire logic        rst_i,
   spm_mem_pipe_if.slave    bus,
   output logic [31:0]      rd_cnt_o,
   output logic [31:0]      wr_cnt_o,
   output logic [31:0]      stall_cnt_o
);
   localparam int c_strb_w = DataWidth / 8;
   localparam int c_off_w  = $clog2(c_strb_w);
   localparam int c_cred_w = $clog2(RspFifoDepth + 1);
   localparam int c_ptr_w  = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
   localparam logic [c_cred_w-1:0] c_cred_max = c_cred_w'(RspFifoDepth);
   localparam logic [c_ptr_w-1:0]  c_ptr_last = c_ptr_w'(RspFifoDepth - 1);

   generate
      if (RspFifoDepth < 1 || RspFifoDepth > 8) begin : g_bad_depth
         $error("spm_mem_pipe: RspFifoDepth must be in 1..8");
      end
      if (c_off_w + SramAddrWidth > AddrWidth) begin : g_bad_addr
         $error("spm_mem_pipe: SRAM word index does not fit in AddrWidth");
      end
   endgenerate

   // Request stage
   logic                     r_stage_valid;
   logic                     r_stage_we;
   logic [SramAddrWidth-1:0] r_stage_addr;
   logic [DataWidth-1:0]     r_stage_wdata;
   logic [c_strb_w-1:0]      r_stage_strb;

   // Read credits and response FIFO
   logic [c_cred_w-1:0]      r_credits;
   logic                     r_rd_pending;
   logic [DataWidth-1:0]     r_fifo_mem [RspFifoDepth];
   logic [c_ptr_w-1:0]       r_wr_ptr;
   logic [c_ptr_w-1:0]       r_rd_ptr;
   logic [c_cred_w-1:0]      r_fifo_cnt;

   logic w_stage_issue;
   logic w_rd_issue;
   logic w_accept;
   logic w_push;
   logic w_pop;

   // Writes never need a credit; a read waits for one, and because the stage
   // is the only buffer, a waiting read also blocks everything behind it.
   assign w_stage_issue = r_stage_valid && (r_stage_we || (r_credits != '0));
   assign w_rd_issue    = w_stage_issue && !r_stage_we;
   assign w_accept      = bus.req_valid_i && bus.req_ready_o;
   assign w_push        = r_rd_pending;
   assign w_pop         = bus.rsp_valid_o && bus.rsp_ready_i;

   // Ready depends only on registered state, never on req_valid_i.
   assign bus.req_ready_o  = !r_stage_valid || w_stage_issue;

   assign bus.sram_req_o   = w_stage_issue;
   assign bus.sram_we_o    = r_stage_we;
   assign bus.sram_addr_o  = r_stage_addr;
   assign bus.sram_wdata_o = r_stage_wdata;
   assign bus.sram_be_o    = r_stage_strb;

   assign bus.rsp_valid_o  = (r_fifo_cnt != '0);
   assign bus.rsp_rdata_o  = r_fifo_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stage_valid <= 1'b0;
      end else if (w_accept) begin
         r_stage_valid <= 1'b1;
      end else if (w_stage_issue) begin
         r_stage_valid <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed while r_stage_valid is set.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_stage_we    <= bus.req_we_i;
         r_stage_addr  <= bus.req_addr_i[c_off_w +: SramAddrWidth];
         r_stage_wdata <= bus.req_wdata_i;
         r_stage_strb  <= bus.req_strb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_credits    <= c_cred_max;
         r_rd_pending <= 1'b0;
      end else begin
         r_rd_pending <= w_rd_issue;
         case ({w_rd_issue, w_pop})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   // The credit scheme bounds issued-but-unpopped reads to RspFifoDepth, so a
   // push always finds a free entry. Clearing r_rd_pending on reset is what
   // discards SRAM data returned for a read issued just before reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= bus.sram_rdata_i;
      end
   end

`ifdef SPM_MEM_PIPE_PERF_EN
   logic        w_wr_issue;
   logic        w_stall;
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;
   logic [31:0] r_stall_cnt;

   assign w_wr_issue = w_stage_issue && r_stage_we;
   assign w_stall    = bus.req_valid_i && !bus.req_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_rd_issue && (r_rd_cnt != 32'hFFFF_FFFF)) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
         if (w_wr_issue && (r_wr_cnt != 32'hFFFF_FFFF)) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign rd_cnt_o    = r_rd_cnt;
   assign wr_cnt_o    = r_wr_cnt;
   assign stall_cnt_o = r_stall_cnt;
`else
   assign rd_cnt_o    = '0;
   assign wr_cnt_o    = '0;
   assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spm_mem_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spm_mem_pipe                                               |
// | Purpose  : Self-checking bench for spm_mem_pipe. Holds an SRAM bank      |
// |            model, a transaction-level reference (pending request queue,  |
// |            outstanding-read count, timed response queue, golden memory)  |
// |            and a per-cycle compare process, plus directed scenarios.     |
// | Config   : SPM_MEM_PIPE_PERF_EN selects expected counter behaviour.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spm_mem_pipe;
   localparam int AW    = 18;
   localparam int DW    = 64;
   localparam int SAW   = 10;
   localparam int DEPTH = 2;
   localparam int SW    = DW / 8;
   localparam int OFF   = $clog2(SW);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;
   logic [31:0] stall_cnt;

   spm_mem_pipe_if #(.AddrWidth(AW), .DataWidth(DW), .SramAddrWidth(SAW)) bus ();

   spm_mem_pipe #(
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .SramAddrWidth (SAW),
      .RspFifoDepth  (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .rd_cnt_o    (rd_cnt),
      .wr_cnt_o    (wr_cnt),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   // SRAM bank: read data appears the cycle after the read strobe, junk otherwise.
   logic [DW-1:0] sram_mem [2**SAW];
   always @(posedge clk) begin
      if (bus.sram_req_o === 1'b1 && bus.sram_we_o === 1'b1) begin
         for (int b = 0; b < SW; b++) begin
            if (bus.sram_be_o[b]) sram_mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
         end
      end
      if (bus.sram_req_o === 1'b1 && bus.sram_we_o === 1'b0) bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
      else                                                   bus.sram_rdata_i <= {$urandom, $urandom};
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          we;
      logic [SAW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
   } req_t;
   typedef struct packed {
      logic [DW-1:0] data;
      logic [31:0]   avail;
   } rsp_t;

   req_t          pend_q[$];
   rsp_t          rsp_q[$];
   logic [DW-1:0] popped_q[$];
   logic [DW-1:0] ref_mem [2**SAW];
   int            outstanding = 0;
   logic [31:0]   cyc = 0;
   int            n_rd_issued = 0;
   int            n_wr_issued = 0;
   int            n_stalls = 0;
   int            n_rsp_valid = 0;
   int            vectors = 0;
   int            miscompares = 0;
   bit            chk_en = 1'b0;

   function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin : compare
         bit   exp_issue;
         bit   exp_valid;
         bit   exp_ready;
         req_t r;
         rsp_t e;
         cyc++;
         exp_issue = (pend_q.size() > 0) && (pend_q[0].we || outstanding < DEPTH);
         exp_valid = (rsp_q.size() > 0) && (rsp_q[0].avail <= cyc);
         exp_ready = (pend_q.size() == 0) || exp_issue;
         check("sram_req", DW'(bus.sram_req_o), DW'(exp_issue));
         check("req_ready", DW'(bus.req_ready_o), DW'(exp_ready));
         check("rsp_valid", DW'(bus.rsp_valid_o), DW'(exp_valid));
         if (exp_valid) check("rsp_rdata", bus.rsp_rdata_o, rsp_q[0].data);
         if (bus.rsp_valid_o === 1'b1) n_rsp_valid++;
         if (exp_valid && bus.rsp_ready_i) begin
            popped_q.push_back(rsp_q[0].data);
            void'(rsp_q.pop_front());
            outstanding--;
         end
         if (exp_issue) begin
            r = pend_q.pop_front();
            check("sram_we", DW'(bus.sram_we_o), DW'(r.we));
            check("sram_addr", DW'(bus.sram_addr_o), DW'(r.addr));
            if (r.we) begin
               check("sram_wdata", bus.sram_wdata_o, r.wdata);
               check("sram_be", DW'(bus.sram_be_o), DW'(r.strb));
               for (int b = 0; b < SW; b++) begin
                  if (r.strb[b]) ref_mem[r.addr][8*b +: 8] = r.wdata[8*b +: 8];
               end
               n_wr_issued++;
            end else begin
               e.data  = ref_mem[r.addr];
               e.avail = cyc + 32'd2;
               rsp_q.push_back(e);
               outstanding++;
               n_rd_issued++;
            end
         end
         if (bus.req_valid_i && !exp_ready) n_stalls++;
         if (bus.req_valid_i && bus.req_ready_o === 1'b1) begin
            r.we    = bus.req_we_i;
            r.addr  = bus.req_addr_i[OFF +: SAW];
            r.wdata = bus.req_wdata_i;
            r.strb  = bus.req_strb_i;
            pend_q.push_back(r);
         end
         if (rst) begin
            pend_q.delete();
            rsp_q.delete();
            outstanding = 0;
            n_rd_issued = 0;
            n_wr_issued = 0;
            n_stalls    = 0;
            n_rsp_valid = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit stall_rel = 1'b0;
   bit rel_pending = 1'b0;
   int stall_seen = 0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb);
      int guard;
      guard = 0;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = data;
      bus.req_strb_i  = strb;
      forever begin
         @(negedge clk);
         if (bus.req_ready_o === 1'b1) break;
         if (stall_rel) begin
            stall_seen++;
            if (stall_seen == 3) rel_pending = 1'b1;
         end
         guard++;
         if (guard > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: request at 0x%0h not accepted in 200 cycles", addr);
            break;
         end
         @(posedge clk); #1;
         if (rel_pending) begin
            bus.rsp_ready_i = 1'b1;
            rel_pending = 1'b0;
            stall_rel = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
   endtask

   initial begin : stim
      int  base_rd;
      int  base_wr;
      bit  acc;
      for (int i = 0; i < 2**SAW; i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.req_strb_i  = '0;
      bus.rsp_ready_i = 1'b1;

      // Reset state
      @(posedge clk); #1;
      chk_en = 1'b1;
      settle();
      check("rst_req_ready", DW'(bus.req_ready_o), 64'd1);
      check("rst_rsp_valid", DW'(bus.rsp_valid_o), 64'd0);
      check("rst_sram_req", DW'(bus.sram_req_o), 64'd0);
      check("rst_cnt", DW'({rd_cnt, wr_cnt} | DW'(stall_cnt)), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Write then read 0x40: word address 8, data back three cycles after acceptance
      send(1'b1, 18'h40, 64'hDEAD_BEEF, 8'hFF);
      settle();
      check("wr40_req", DW'(bus.sram_req_o), 64'd1);
      check("wr40_we", DW'(bus.sram_we_o), 64'd1);
      check("wr40_addr", DW'(bus.sram_addr_o), 64'h8);
      check("wr40_wdata", bus.sram_wdata_o, 64'hDEAD_BEEF);
      tick();
      send(1'b0, 18'h40, '0, '0);
      settle();
      check("rd40_req", DW'(bus.sram_req_o), 64'd1);
      check("rd40_we", DW'(bus.sram_we_o), 64'd0);
      check("rd40_addr", DW'(bus.sram_addr_o), 64'h8);
      tick();
      settle();
      check("rd40_lat2", DW'(bus.rsp_valid_o), 64'd0);
      tick();
      settle();
      check("rd40_lat3", DW'(bus.rsp_valid_o), 64'd1);
      check("rd40_data", bus.rsp_rdata_o, 64'hDEAD_BEEF);
      tick();

      // Back-to-back reads 0x0/0x8/0x10, in-order responses
      send(1'b1, 18'h00, 64'h1111_0000_AAAA_0001, 8'hFF);
      send(1'b1, 18'h08, 64'h2222_0000_BBBB_0002, 8'hFF);
      send(1'b1, 18'h10, 64'h3333_0000_CCCC_0003, 8'h0F);
      idle(2);
      popped_q.delete();
      send(1'b0, 18'h00, '0, '0);
      send(1'b0, 18'h08, '0, '0);
      send(1'b0, 18'h10, '0, '0);
      idle(8);
      check("b2b_count", DW'(popped_q.size()), 64'd3);
      if (popped_q.size() == 3) begin
         check("b2b_rsp0", popped_q[0], 64'h1111_0000_AAAA_0001);
         check("b2b_rsp1", popped_q[1], 64'h2222_0000_BBBB_0002);
         check("b2b_rsp2", popped_q[2], 64'h0000_0000_CCCC_0003);
      end

      // Credit exhaustion: third read held, younger write held behind it
      bus.rsp_ready_i = 1'b0;
      base_rd = n_rd_issued;
      base_wr = n_wr_issued;
      send(1'b0, 18'h100, '0, '0);
      send(1'b0, 18'h108, '0, '0);
      send(1'b0, 18'h110, '0, '0);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_addr_i  = 18'h200;
      bus.req_wdata_i = 64'h5A5A;
      bus.req_strb_i  = 8'h03;
      settle();
      check("cred_rd_issued", DW'(n_rd_issued - base_rd), 64'd2);
      check("cred_ready0", DW'(bus.req_ready_o), 64'd0);
      tick();
      settle();
      check("inorder_wr_held", DW'(n_wr_issued - base_wr), 64'd0);
      tick();
      bus.rsp_ready_i = 1'b1;
      settle();
      check("cred_pop_cycle", DW'(n_rd_issued - base_rd), 64'd2);
      tick();
      bus.rsp_ready_i = 1'b0;
      settle();
      check("cred_rd3_issued", DW'(n_rd_issued - base_rd), 64'd3);
      check("cred_ready1", DW'(bus.req_ready_o), 64'd1);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      check("inorder_wr_issued", DW'(n_wr_issued - base_wr), 64'd1);
      tick();
      bus.rsp_ready_i = 1'b1;
      idle(8);

      // Reset one cycle after a read issues: its response never appears
      send(1'b0, 18'h300, '0, '0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(8);
      settle();
      check("rst_drop_rsp", DW'(n_rsp_valid), 64'd0);
      check("rst_drop_ready", DW'(bus.req_ready_o), 64'd1);
      tick();
      base_rd = n_rd_issued;
      send(1'b0, 18'h00, '0, '0);
      send(1'b0, 18'h08, '0, '0);
      settle();
      check("rst_credits", DW'(n_rd_issued - base_rd), 64'd2);
      tick();
      idle(6);

      // Counters: 5 reads, 2 writes, 4 stall cycles
      do_reset();
      bus.rsp_ready_i = 1'b0;
      stall_seen = 0;
      stall_rel  = 1'b1;
      send(1'b0, 18'h040, '0, '0);
      send(1'b0, 18'h048, '0, '0);
      send(1'b0, 18'h050, '0, '0);
      send(1'b0, 18'h058, '0, '0);
      bus.rsp_ready_i = 1'b1;
      idle(4);
      send(1'b0, 18'h060, '0, '0);
      idle(3);
      send(1'b1, 18'h068, 64'h77, 8'h01);
      send(1'b1, 18'h070, 64'h88, 8'h01);
      idle(4);
      settle();
      check("model_rd5", DW'(n_rd_issued), 64'd5);
      check("model_wr2", DW'(n_wr_issued), 64'd2);
      check("model_stall4", DW'(n_stalls), 64'd4);
`ifdef SPM_MEM_PIPE_PERF_EN
      check("perf_rd", DW'(rd_cnt), 64'd5);
      check("perf_wr", DW'(wr_cnt), 64'd2);
      check("perf_stall", DW'(stall_cnt), 64'd4);
`else
      check("perf_rd", DW'(rd_cnt), 64'd0);
      check("perf_wr", DW'(wr_cnt), 64'd0);
      check("perf_stall", DW'(stall_cnt), 64'd0);
`endif
      tick();

      // Random traffic with random backpressure and occasional reset
      do_reset();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         acc = bus.req_valid_i && (bus.req_ready_o === 1'b1);
         @(posedge clk); #1;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 149) == 0) rst = 1'b1;
         if (acc || !bus.req_valid_i || rst) begin
            bus.req_valid_i = !rst && ($urandom_range(0, 9) < 7);
            bus.req_we_i    = ($urandom_range(0, 2) == 0);
            bus.req_addr_i  = AW'(($urandom_range(0, 31) << OFF) | $urandom_range(0, SW - 1));
            bus.req_wdata_i = {$urandom, $urandom};
            bus.req_strb_i  = SW'($urandom);
         end
         bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      idle(10);
      settle();
`ifdef SPM_MEM_PIPE_PERF_EN
      check("rand_rd_cnt", DW'(rd_cnt), DW'(n_rd_issued));
      check("rand_wr_cnt", DW'(wr_cnt), DW'(n_wr_issued));
      check("rand_stall_cnt", DW'(stall_cnt), DW'(n_stalls));
`else
      check("rand_rd_cnt", DW'(rd_cnt), 64'd0);
      check("rand_wr_cnt", DW'(wr_cnt), 64'd0);
      check("rand_stall_cnt", DW'(stall_cnt), 64'd0);
`endif
      check("rand_drained", DW'(rsp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
